// File: rtl/bellek_hakem.sv
// Two-requester round-robin memory arbiter. Each access is accepted, performed
// and answered in a fixed three-cycle sequence.
module bellek_hakem #(
    parameter logic [31:0] BASLANGIC_ADRES = 32'h8000_0000,
    parameter logic [31:0] BITIS_ADRES     = 32'h8000_0800
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  istek_gecerli,
    input  logic [1:0]  istek_yaz,
    input  logic [63:0] istek_adres,
    input  logic [63:0] istek_veri,
    output logic [1:0]  istek_hazir,
    output logic [1:0]  yanit_gecerli,
    output logic [31:0] yanit_veri,
    output logic        yanit_hata,
    output logic [31:0] bellek_adres,
    output logic [31:0] bellek_yaz_veri,
    output logic        bellek_yaz_gecerli,
    input  logic [31:0] bellek_oku_veri
);

    typedef enum logic [1:0] {
        BOSTA  = 2'd0,
        ERISIM = 2'd1,
        YANIT  = 2'd2
    } durum_t;

    durum_t      durum;
    durum_t      sonraki;

    logic        son_hizmet;
    logic        hizmet;
    logic        yaz_kayit;
    logic [31:0] adres_kayit;
    logic [31:0] veri_kayit;
    logic [31:0] yanit_kayit;
    logic        hata_kayit;

    logic        secilen;
    logic        kabul;
    logic        yasal;

    // Round-robin choice: under contention the requester not served last wins.
    always_comb begin
        secilen = 1'b0;
        case (istek_gecerli)
            2'b01:   secilen = 1'b0;
            2'b10:   secilen = 1'b1;
            2'b11:   secilen = ~son_hizmet;
            default: secilen = 1'b0;
        endcase
    end

    assign kabul = (durum == BOSTA) && (|istek_gecerli) && rst_n;

    assign yasal = (adres_kayit >= BASLANGIC_ADRES) &&
                   (adres_kayit <  BITIS_ADRES) &&
                   (adres_kayit[1:0] == 2'b00);

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        sonraki            = durum;
        istek_hazir        = 2'b00;
        yanit_gecerli      = 2'b00;
        bellek_yaz_gecerli = 1'b0;
        case (durum)
            BOSTA: begin
                if (|istek_gecerli) begin
                    sonraki = ERISIM;
                    istek_hazir[secilen] = rst_n;
                end
            end
            ERISIM: begin
                sonraki            = YANIT;
                bellek_yaz_gecerli = yaz_kayit && yasal && rst_n;
            end
            YANIT: begin
                sonraki               = BOSTA;
                yanit_gecerli[hizmet] = rst_n;
            end
            default: sonraki = BOSTA;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            durum       <= BOSTA;
            son_hizmet  <= 1'b1;
            hizmet      <= 1'b0;
            yaz_kayit   <= 1'b0;
            adres_kayit <= '0;
            veri_kayit  <= '0;
            yanit_kayit <= '0;
            hata_kayit  <= 1'b0;
        end else begin
            durum <= sonraki;
            if (kabul) begin
                hizmet      <= secilen;
                yaz_kayit   <= istek_yaz[secilen];
                adres_kayit <= secilen ? istek_adres[63:32] : istek_adres[31:0];
                veri_kayit  <= secilen ? istek_veri[63:32]  : istek_veri[31:0];
            end
            if (durum == ERISIM) begin
                yanit_kayit <= (yasal && !yaz_kayit) ? bellek_oku_veri : 32'h0;
                hata_kayit  <= !yasal;
            end
            if (durum == YANIT) begin
                son_hizmet <= hizmet;
            end
        end
    end

    // Held at zero while reset is asserted, before the clearing edge lands.
    assign bellek_adres    = rst_n ? adres_kayit : 32'h0;
    assign bellek_yaz_veri = rst_n ? veri_kayit  : 32'h0;
    assign yanit_veri      = rst_n ? yanit_kayit : 32'h0;
    assign yanit_hata      = rst_n && hata_kayit;

endmodule

// File: tb/tb_bellek_hakem.sv
// Bench for bellek_hakem: directed vector table, hand-written reset/contention
// sequences and random traffic checked against a transaction-level model.
module tb_bellek_hakem;

    localparam logic [31:0] BAS = 32'h8000_0000;
    localparam logic [31:0] BIT = 32'h8000_0800;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  istek_gecerli = 2'b00;
    logic [1:0]  istek_yaz = 2'b00;
    logic [63:0] istek_adres = 64'h0;
    logic [63:0] istek_veri = 64'h0;
    logic [1:0]  istek_hazir;
    logic [1:0]  yanit_gecerli;
    logic [31:0] yanit_veri;
    logic        yanit_hata;
    logic [31:0] bellek_adres;
    logic [31:0] bellek_yaz_veri;
    logic        bellek_yaz_gecerli;
    logic [31:0] bellek_oku_veri;

    always #5 clk = ~clk;

    bellek_hakem #(
        .BASLANGIC_ADRES(BAS),
        .BITIS_ADRES(BIT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .istek_gecerli(istek_gecerli),
        .istek_yaz(istek_yaz),
        .istek_adres(istek_adres),
        .istek_veri(istek_veri),
        .istek_hazir(istek_hazir),
        .yanit_gecerli(yanit_gecerli),
        .yanit_veri(yanit_veri),
        .yanit_hata(yanit_hata),
        .bellek_adres(bellek_adres),
        .bellek_yaz_veri(bellek_yaz_veri),
        .bellek_yaz_gecerli(bellek_yaz_gecerli),
        .bellek_oku_veri(bellek_oku_veri)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : (32'h5A00_0000 + 32'(i) * 32'h0001_0003);
    endfunction

    // Memory seen by the DUT.
    logic [31:0] mem [512];
    logic        mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 512; i++) mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (bellek_yaz_gecerli) begin
            mem[bellek_adres[10:2]] <= bellek_yaz_veri;
        end
    end
    assign bellek_oku_veri = (bellek_adres >= BAS && bellek_adres < BIT) ?
                             mem[bellek_adres[10:2]] : 32'hBAD0_0BAD;

    // Reference model: expected memory image and last-served requester.
    logic [31:0] ref_mem [512];
    int          son = 1;
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic bit legal(input logic [31:0] a);
        return (a >= BAS) && (a < BIT) && (a[1:0] == 2'b00);
    endfunction

    task automatic model_expect(input logic [1:0] v, input logic [1:0] w, input logic [63:0] a,
                                output logic [1:0] hz, output logic [31:0] veri, output logic hata);
        int k;
        logic [31:0] ad;
        hz = 2'b00; veri = 32'h0; hata = 1'b0;
        if (v == 2'b00) return;
        k  = (v == 2'b01) ? 0 : (v == 2'b10) ? 1 : 1 - son;
        hz = (k == 0) ? 2'b01 : 2'b10;
        ad = a[k*32 +: 32];
        hata = !legal(ad);
        if (legal(ad) && !w[k]) veri = ref_mem[int'((ad - BAS) >> 2)];
    endtask

    // One arbitration slot: an idle cycle, or accept / access / response.
    task automatic slot(input string tag, input logic [1:0] v, input logic [1:0] w,
                        input logic [63:0] a, input logic [63:0] d, input logic [1:0] exp_hz,
                        input logic [31:0] exp_veri, input logic exp_hata, input bit scramble);
        int k;
        logic [31:0] ad;
        logic        lg;
        @(negedge clk);
        istek_gecerli = v; istek_yaz = w; istek_adres = a; istek_veri = d;
        #1;
        check({tag, " hazir"}, 32'(istek_hazir), 32'(exp_hz));
        if (exp_hz == 2'b00) begin
            check({tag, " idle yanit_gecerli"}, 32'(yanit_gecerli), 32'h0);
            return;
        end
        k  = exp_hz[1] ? 1 : 0;
        ad = a[k*32 +: 32];
        lg = !exp_hata;
        @(negedge clk);
        if (scramble) begin
            istek_gecerli = 2'($urandom); istek_yaz = 2'($urandom);
            istek_adres = {$urandom, $urandom}; istek_veri = {$urandom, $urandom};
        end
        #1;
        check({tag, " erisim hazir"}, 32'(istek_hazir), 32'h0);
        check({tag, " yaz_gecerli"}, 32'(bellek_yaz_gecerli), 32'(lg && w[k]));
        check({tag, " bellek_adres"}, bellek_adres, ad);
        check({tag, " bellek_yaz_veri"}, bellek_yaz_veri, d[k*32 +: 32]);
        check({tag, " erisim yanit_gecerli"}, 32'(yanit_gecerli), 32'h0);
        @(negedge clk);
        if (scramble) begin
            istek_gecerli = 2'($urandom); istek_yaz = 2'($urandom);
        end
        #1;
        check({tag, " yanit hazir"}, 32'(istek_hazir), 32'h0);
        check({tag, " yanit_gecerli"}, 32'(yanit_gecerli), 32'(exp_hz));
        check({tag, " yanit_veri"}, yanit_veri, exp_veri);
        check({tag, " yanit_hata"}, 32'(yanit_hata), 32'(exp_hata));
        check({tag, " yanit yaz_gecerli"}, 32'(bellek_yaz_gecerli), 32'h0);
        son = k;
        if (lg && w[k]) ref_mem[int'((ad - BAS) >> 2)] = d[k*32 +: 32];
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " hazir"}, 32'(istek_hazir), 32'h0);
        check({tag, " yanit_gecerli"}, 32'(yanit_gecerli), 32'h0);
        check({tag, " yanit_hata"}, 32'(yanit_hata), 32'h0);
        check({tag, " yaz_gecerli"}, 32'(bellek_yaz_gecerli), 32'h0);
        check({tag, " bellek_adres"}, bellek_adres, 32'h0);
        check({tag, " bellek_yaz_veri"}, bellek_yaz_veri, 32'h0);
        check({tag, " yanit_veri"}, yanit_veri, 32'h0);
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = $urandom_range(0, 9);
        case (sel)
            0:       return BIT + (32'($urandom_range(0, 15)) << 2);
            1:       return BAS - 32'h4;
            2:       return BAS + (32'($urandom_range(0, 63)) << 2) + 32'($urandom_range(1, 3));
            default: return BAS + (32'($urandom_range(0, 63)) << 2);
        endcase
    endfunction

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  w;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [31:0] d0;
        logic [31:0] d1;
        logic [1:0]  hz;
        logic [31:0] veri;
        logic        hata;
    } vec_t;

    vec_t tbl [12];

    initial begin
        logic [1:0]  hz;
        logic [31:0] veri;
        logic        hata;
        logic [1:0]  v, w;
        logic [63:0] a, d;
        int          bad_words;

        tbl[0]  = '{2'b01, 2'b00, 32'h8000_0010, 32'h0,          32'h0,          32'h0,          2'b01, 32'hDEAD_BEEF, 1'b0};
        tbl[1]  = '{2'b10, 2'b10, 32'h0,          32'h8000_0020, 32'h0,          32'h1234_5678, 2'b10, 32'h0,         1'b0};
        tbl[2]  = '{2'b10, 2'b00, 32'h0,          32'h8000_0020, 32'h0,          32'h0,          2'b10, 32'h1234_5678, 1'b0};
        tbl[3]  = '{2'b10, 2'b10, 32'h0,          32'h8000_0800, 32'h0,          32'h1111_1111, 2'b10, 32'h0,         1'b1};
        tbl[4]  = '{2'b01, 2'b01, 32'h8000_0012, 32'h0,          32'hCAFE_BABE, 32'h0,          2'b01, 32'h0,         1'b1};
        tbl[5]  = '{2'b01, 2'b00, 32'h7FFF_FFFC, 32'h0,          32'h0,          32'h0,          2'b01, 32'h0,         1'b1};
        tbl[6]  = '{2'b01, 2'b00, 32'h8000_07FC, 32'h0,          32'h0,          32'h0,          2'b01, 32'h5BFF_05FD, 1'b0};
        tbl[7]  = '{2'b11, 2'b00, 32'h8000_0010, 32'h8000_0020, 32'h0,          32'h0,          2'b10, 32'h1234_5678, 1'b0};
        tbl[8]  = '{2'b11, 2'b00, 32'h8000_0004, 32'h8000_0020, 32'h0,          32'h0,          2'b01, 32'h5A01_0003, 1'b0};
        tbl[9]  = '{2'b11, 2'b00, 32'h8000_0010, 32'h8000_0020, 32'h0,          32'h0,          2'b10, 32'h1234_5678, 1'b0};
        tbl[10] = '{2'b11, 2'b00, 32'h8000_0010, 32'h8000_0020, 32'h0,          32'h0,          2'b01, 32'hDEAD_BEEF, 1'b0};
        tbl[11] = '{2'b00, 2'b00, 32'h0,          32'h0,          32'h0,          32'h0,          2'b00, 32'h0,         1'b0};

        for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);

        // Reset with requests pending: nothing may be granted.
        istek_gecerli = 2'b11;
        repeat (3) @(negedge clk);
        #1;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        istek_gecerli = 2'b00;
        #1;
        check_idle_outputs("post reset");
        son = 1;

        for (int i = 0; i < 12; i++) begin
            slot($sformatf("vec%0d", i), tbl[i].v, tbl[i].w, {tbl[i].a1, tbl[i].a0},
                 {tbl[i].d1, tbl[i].d0}, tbl[i].hz, tbl[i].veri, tbl[i].hata, 1'b0);
        end

        for (int i = 0; i < 200; i++) begin
            v = 2'($urandom); w = 2'($urandom);
            a = {rand_addr(), rand_addr()};
            d = {$urandom, $urandom};
            model_expect(v, w, a, hz, veri, hata);
            slot($sformatf("rnd%0d", i), v, w, a, d, hz, veri, hata, 1'b1);
        end

        // Reset during the access cycle of a legal write aborts it.
        @(negedge clk);
        istek_gecerli = 2'b10; istek_yaz = 2'b10;
        istek_adres = {32'h8000_0040, 32'h0}; istek_veri = {32'hFEED_F00D, 32'h0};
        #1;
        check("abort hazir", 32'(istek_hazir), 32'h2);
        @(negedge clk);
        rst_n = 1'b0;
        istek_gecerli = 2'b00;
        #1;
        check("abort yaz_gecerli", 32'(bellek_yaz_gecerli), 32'h0);
        check("abort yanit_gecerli", 32'(yanit_gecerli), 32'h0);
        @(negedge clk);
        #1;
        check_idle_outputs("abort in reset");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_idle_outputs("abort released");
        son = 1;

        // Continuous contention right after reset alternates 0,1,0,1.
        for (int i = 0; i < 4; i++) begin
            a = {32'h8000_0020, 32'h8000_0010};
            model_expect(2'b11, 2'b00, a, hz, veri, hata);
            check($sformatf("rr order %0d", i), 32'(hz), (i % 2 == 0) ? 32'h1 : 32'h2);
            slot($sformatf("rr%0d", i), 2'b11, 2'b00, a, 64'h0, hz, veri, hata, 1'b0);
        end

        @(negedge clk);
        istek_gecerli = 2'b00;
        @(negedge clk);
        bad_words = 0;
        for (int i = 0; i < 512; i++) if (mem[i] !== ref_mem[i]) bad_words++;
        check("memory image words differing", 32'(bad_words), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bellek_hakem.md
BELLEK_HAKEM -- requirements
Module: bellek_hakem

Interface
REQ-001 SHALL have parameter BASLANGIC_ADRES, default 32'h8000_0000, meaning the lowest legal byte address.
REQ-002 SHALL have parameter BITIS_ADRES, default 32'h8000_0800, meaning the exclusive upper legal byte address.
REQ-003 SHALL have the following ports, one per line: name, direction, width, meaning.
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  reset; synchronous and active-low.
- istek_gecerli  in  2  request valid; bit 0 = fetch requester, bit 1 = data requester.
- istek_yaz  in  2  1 = write, 0 = read, per requester.
- istek_adres  in  64  byte address, {req1[31:0], req0[31:0]}.
- istek_veri  in  64  write data, same packing.
- istek_hazir  out  2  request accepted this cycle, per requester.
- yanit_gecerli  out  2  one-cycle response strobe, per requester.
- yanit_veri  out  32  read data; shared bus, meaningful only with yanit_gecerli.
- yanit_hata  out  1  error flag; qualified by yanit_gecerli.
- bellek_adres  out  32  address to memory.
- bellek_yaz_veri  out  32  write data to memory.
- bellek_yaz_gecerli  out  1  memory write enable.
- bellek_oku_veri  in  32  memory read data; combinational from bellek_adres.

Function
REQ-004 SHALL implement FSM states BOSTA, ERISIM and YANIT.
- BOSTA to ERISIM on any istek_gecerli bit.
- ERISIM to YANIT unconditionally.
- YANIT to BOSTA unconditionally.
REQ-005 SHALL assert istek_hazir[k] combinationally, only in BOSTA, for the single granted requester k; at most one bit is high in any cycle.
REQ-006 SHALL, on the accepting edge, latch the grant index, address, write flag and write data of requester k.
REQ-007 SHALL arbitrate round-robin using a registered son_hizmet bit.
- Only one requester valid: it wins.
- Both valid: the requester not equal to son_hizmet wins.
- son_hizmet updates to k in YANIT.
REQ-008 SHALL drive bellek_adres and bellek_yaz_veri from the latched registers in every state; the latched registers hold their value outside the accept edge.
REQ-009 SHALL assert bellek_yaz_gecerli for exactly one cycle, in ERISIM, only for a legal write, and only when rst_n=1.
REQ-010 SHALL classify an access as legal when BASLANGIC_ADRES <= address < BITIS_ADRES and address[1:0] == 2'b00.
REQ-011 SHALL, in ERISIM, register the response.
- Legal read: yanit_veri <= bellek_oku_veri, hata <= 0.
- Legal write: yanit_veri <= 0, hata <= 0.
- Illegal access: yanit_veri <= 0, hata <= 1, and no memory write.
REQ-012 SHALL assert yanit_gecerli[k] and the registered yanit_hata for exactly one cycle, in YANIT.
REQ-013 SHALL have fixed timing: accept at cycle T, response strobe at T+2, next accept earliest at T+3; throughput is one access per 3 cycles.
REQ-014 SHALL not require requesters to keep istek_gecerli asserted after acceptance; a request still held in YANIT is treated as a new request in the next BOSTA.
REQ-015 SHALL ignore istek_gecerli changes in ERISIM and YANIT; no request is lost, because acceptance occurs only via istek_hazir.

Reset
REQ-016 SHALL, on a clock edge with rst_n=0, enter BOSTA and clear all registers.
- son_hizmet <= 1, so requester 0 wins the first contention.
- Latched address and data, grant index, yanit_veri and hata all <= 0.
REQ-017 SHALL drive these outputs during and after reset until the next accept: istek_hazir=0, yanit_gecerli=0, yanit_hata=0, bellek_yaz_gecerli=0, bellek_adres=0, bellek_yaz_veri=0, yanit_veri=0.
REQ-018 SHALL, when reset occurs in ERISIM or YANIT, abort the access.
- No memory write and no response strobe is issued.
- Requesters reissue the access.

Verification
REQ-019 Single read: req0 reads 32'h8000_0010, memory holds 32'hDEAD_BEEF -> istek_hazir=2'b01 at T, yanit_gecerli=2'b01 at T+2, yanit_veri=32'hDEAD_BEEF, yanit_hata=0.
REQ-020 Write then read: req1 writes 32'h1234_5678 to 32'h8000_0020, then reads it -> bellek_yaz_gecerli high exactly one cycle; the read returns 32'h1234_5678.
REQ-021 Contention: both valid continuously after reset -> grant order 0,1,0,1 with accepts at cycles T, T+3, T+6, T+9.
REQ-022 Illegal access: writes to 32'h8000_0800 and 32'h8000_0012 -> yanit_hata=1, yanit_veri=0, bellek_yaz_gecerli never asserts, memory unchanged.
REQ-023 Reset mid-operation: rst_n=0 during the ERISIM cycle of a legal write -> no memory write, no yanit_gecerli, outputs per REQ-017, next request granted to req0.
